adda_adc_capture: RTL and testbench

//   Front end for the J2 ADDA board ADC. Generates the ADC sample clock (o_ad_clk)

---
 rtl/adda_adc_capture.sv | 125 ++++++++++++
 tb/tb_adda_adc_capture.sv | 256 +++++++++++++++++++++++++
 2 files changed

// File: rtl/adda_adc_capture.sv
// J2 ADDA ADC front end: divides i_clk into the ADC sample clock, captures the
// parallel ADC bus once per sample period and buffers samples in a small FWFT FIFO.
module adda_adc_capture #(
  parameter int unsigned CLK_DIV    = 2,
  parameter int unsigned DATA_W     = 8,
  parameter int unsigned FIFO_DEPTH = 4
) (
  input  logic                              i_clk,
  input  logic                              i_rst,
  input  logic                              i_enable,
  output logic                              o_ad_clk,
  input  logic [DATA_W-1:0]                 i_ad_port,
  output logic [DATA_W-1:0]                 o_data,
  output logic                              o_valid,
  input  logic                              i_ready,
  output logic [$clog2(FIFO_DEPTH):0]       o_level,
  output logic                              o_overrun,
  output logic [7:0]                        o_drop_count,
  input  logic                              i_clr_overrun
);

  localparam int unsigned DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam int unsigned PTR_W = $clog2(FIFO_DEPTH);
  localparam int unsigned LVL_W = PTR_W + 1;
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);
  localparam logic [LVL_W-1:0] LVL_FULL = LVL_W'(FIFO_DEPTH);

  logic [DIV_W-1:0]  div_cnt;
  logic              ad_clk_q;
  logic [DATA_W-1:0] ad_q;
  logic [DATA_W-1:0] mem [FIFO_DEPTH];
  logic [PTR_W-1:0]  wr_ptr;
  logic [PTR_W-1:0]  rd_ptr;
  logic [LVL_W-1:0]  level_q;
  logic              valid_q;
  logic [DATA_W-1:0] data_q;
  logic              overrun_q;
  logic [7:0]        drop_q;

  logic              strobe;
  logic              full;
  logic              pop;
  logic              push;
  logic              drop;
  logic [PTR_W-1:0]  rd_ptr_nxt;
  logic [LVL_W-1:0]  level_nxt;
  logic [DATA_W-1:0] head_nxt;

  // Sample clock divider; disabling parks the clock low with a cleared count.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      div_cnt  <= '0;
      ad_clk_q <= 1'b0;
    end else if (!i_enable) begin
      div_cnt  <= '0;
      ad_clk_q <= 1'b0;
    end else if (div_cnt == DIV_LAST) begin
      div_cnt  <= '0;
      ad_clk_q <= ~ad_clk_q;
    end else begin
      div_cnt  <= div_cnt + DIV_W'(1);
    end
  end

  // Pin register for the ADC bus.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) ad_q <= '0;
    else       ad_q <= i_ad_port;
  end

  // FIFO control; the head is precomputed so o_data stays a flop output.
  always_comb begin
    strobe     = i_enable & ad_clk_q & (div_cnt == DIV_LAST);
    full       = (level_q == LVL_FULL);
    pop        = valid_q & i_ready;
    push       = strobe & (~full | pop);
    drop       = strobe & full & ~pop;
    rd_ptr_nxt = pop ? rd_ptr + PTR_W'(1) : rd_ptr;
    level_nxt  = level_q + LVL_W'(push) - LVL_W'(pop);
    head_nxt   = (push && (wr_ptr == rd_ptr_nxt)) ? ad_q : mem[rd_ptr_nxt];
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      for (int unsigned i = 0; i < FIFO_DEPTH; i++) mem[i] <= '0;
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      level_q <= '0;
      valid_q <= 1'b0;
      data_q  <= '0;
    end else begin
      if (push) begin
        mem[wr_ptr] <= ad_q;
        wr_ptr      <= wr_ptr + PTR_W'(1);
      end
      rd_ptr  <= rd_ptr_nxt;
      level_q <= level_nxt;
      valid_q <= (level_nxt != '0);
      data_q  <= head_nxt;
    end
  end

  // Sticky overrun flag and saturating drop counter; a drop beats a clear.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      overrun_q <= 1'b0;
      drop_q    <= '0;
    end else if (drop) begin
      overrun_q <= 1'b1;
      if (i_clr_overrun)      drop_q <= 8'd1;
      else if (drop_q != 8'hFF) drop_q <= drop_q + 8'd1;
    end else if (i_clr_overrun) begin
      overrun_q <= 1'b0;
      drop_q    <= '0;
    end
  end

  assign o_ad_clk     = ad_clk_q;
  assign o_data       = data_q;
  assign o_valid      = valid_q;
  assign o_level      = level_q;
  assign o_overrun    = overrun_q;
  assign o_drop_count = drop_q;

endmodule

// File: tb/tb_adda_adc_capture.sv
// Scenario bench for adda_adc_capture (CLK_DIV=2, DATA_W=8, FIFO_DEPTH=4) with a sample queue.
module tb_adda_adc_capture;

  logic       clk = 1'b0;
  logic       rst;
  logic       enable;
  logic       ad_clk;
  logic [7:0] port;
  logic [7:0] data;
  logic       valid;
  logic       ready;
  logic [2:0] level;
  logic       ovr;
  logic [7:0] drop;
  logic       clr;

  int         checks = 0;
  int         errors = 0;
  logic [7:0] exp_q[$];
  logic       prev_ad_clk;
  logic       strobe_seen;

  adda_adc_capture #(.CLK_DIV(2), .DATA_W(8), .FIFO_DEPTH(4)) dut (
    .i_clk(clk), .i_rst(rst), .i_enable(enable), .o_ad_clk(ad_clk),
    .i_ad_port(port), .o_data(data), .o_valid(valid), .i_ready(ready),
    .o_level(level), .o_overrun(ovr), .o_drop_count(drop), .i_clr_overrun(clr)
  );

  always #5 clk = ~clk;

  // Advance to the next falling edge; a high-to-low o_ad_clk step marks a capture edge.
  task automatic tick();
    @(negedge clk);
    strobe_seen = prev_ad_clk & ~ad_clk;
    prev_ad_clk = ad_clk;
  endtask

  task automatic do_reset();
    enable = 1'b0; ready = 1'b0; clr = 1'b0; port = 8'h00;
    rst = 1'b1;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    prev_ad_clk = 1'b0;
    exp_q.delete();
  endtask

  // Run with i_ready low until n captures; only the first four fit the FIFO.
  task automatic run_strobes(input int n);
    int seen = 0;
    int cyc = 0;
    while (seen < n && cyc < 200) begin
      tick();
      cyc++;
      if (strobe_seen) begin
        seen++;
        if (exp_q.size() < 4) exp_q.push_back(port);
        port = port + 8'd1;
      end
    end
    if (seen < n) begin
      checks++; errors++;
      $display("FAIL strobe_timeout: got %0d captures, required %0d", seen, n);
    end
  endtask

  // Stop on the last cycle of the o_ad_clk high phase.
  task automatic wait_strobe_cycle();
    logic p;
    int cyc = 0;
    do begin
      p = ad_clk;
      tick();
      cyc++;
    end while (!(p && ad_clk) && cyc < 40);
    if (!(p && ad_clk)) begin
      checks++; errors++;
      $display("FAIL strobe_cycle_timeout: no high-phase end within %0d cycles", cyc);
    end
  endtask

  task automatic test_reset();
    int bad = 0;
    do_reset();
    port = 8'h55; enable = 1'b1;
    run_strobes(2);
    #2 rst = 1'b1;
    #1;
    checks++; if (ad_clk !== 1'b0) begin errors++; $display("FAIL rst_ad_clk: got %b required 0", ad_clk); end
    checks++; if (valid !== 1'b0) begin errors++; $display("FAIL rst_valid: got %b required 0", valid); end
    checks++; if (data !== 8'h00) begin errors++; $display("FAIL rst_data: got %h required 00", data); end
    checks++; if (level !== 3'd0) begin errors++; $display("FAIL rst_level: got %0d required 0", level); end
    checks++; if (ovr !== 1'b0) begin errors++; $display("FAIL rst_overrun: got %b required 0", ovr); end
    checks++; if (drop !== 8'd0) begin errors++; $display("FAIL rst_drop: got %0d required 0", drop); end
    enable = 1'b0;
    @(negedge clk);
    rst = 1'b0; prev_ad_clk = 1'b0; exp_q.delete();
    for (int i = 0; i < 6; i++) begin
      tick();
      if (ad_clk !== 1'b0 || valid !== 1'b0) bad++;
    end
    checks++; if (bad != 0) begin errors++; $display("FAIL rst_idle: got %0d active cycles required 0", bad); end
  endtask

  task automatic test_clock();
    logic e;
    int cyc = 0;
    do_reset();
    ready = 1'b1; enable = 1'b1;
    for (int n = 1; n <= 16; n++) begin
      tick();
      e = ((n / 2) % 2) == 1;
      checks++;
      if (ad_clk !== e) begin errors++; $display("FAIL clk_wave n=%0d: got %b required %b", n, ad_clk, e); end
    end
    while (ad_clk !== 1'b1 && cyc < 8) begin tick(); cyc++; end
    enable = 1'b0;
    tick();
    checks++; if (ad_clk !== 1'b0) begin errors++; $display("FAIL clk_disable: got %b required 0", ad_clk); end
    repeat (4) tick();
    checks++; if (ad_clk !== 1'b0) begin errors++; $display("FAIL clk_parked: got %b required 0", ad_clk); end
  endtask

  task automatic test_capture();
    logic [7:0] e;
    int strobes = 0;
    int pulses = 0;
    int cyc = 0;
    do_reset();
    port = 8'hCC; ready = 1'b1; enable = 1'b1;
    while (strobes < 5 && cyc < 80) begin
      tick();
      cyc++;
      if (strobe_seen) begin
        strobes++;
        exp_q.push_back(port);
        port = port + 8'd1;
      end
      if (valid === 1'b1) begin
        pulses++;
        e = (exp_q.size() > 0) ? exp_q.pop_front() : 8'hXX;
        checks++;
        if (data !== e) begin errors++; $display("FAIL capture_data: got %h required %h", data, e); end
      end
    end
    enable = 1'b0;
    repeat (3) begin
      tick();
      if (valid === 1'b1) pulses++;
    end
    checks++; if (pulses != 5) begin errors++; $display("FAIL capture_pulses: got %0d required 5", pulses); end
    checks++; if (exp_q.size() != 0) begin errors++; $display("FAIL capture_missing: got %0d unread required 0", exp_q.size()); end
  endtask

  task automatic test_overrun();
    logic [7:0] e;
    int k = 0;
    do_reset();
    port = 8'h10; enable = 1'b1;
    run_strobes(6);
    enable = 1'b0;
    tick();
    checks++; if (level !== 3'd4) begin errors++; $display("FAIL ovr_level: got %0d required 4", level); end
    checks++; if (ovr !== 1'b1) begin errors++; $display("FAIL ovr_flag: got %b required 1", ovr); end
    checks++; if (drop !== 8'd2) begin errors++; $display("FAIL ovr_count: got %0d required 2", drop); end
    checks++; if (data !== 8'h10) begin errors++; $display("FAIL ovr_head: got %h required 10", data); end
    clr = 1'b1;
    tick();
    clr = 1'b0;
    checks++; if (ovr !== 1'b0 || drop !== 8'd0) begin errors++; $display("FAIL ovr_clear: got %b/%0d required 0/0", ovr, drop); end
    checks++; if (level !== 3'd4) begin errors++; $display("FAIL ovr_clear_level: got %0d required 4", level); end
    enable = 1'b1;
    wait_strobe_cycle();
    clr = 1'b1;
    tick();
    clr = 1'b0; enable = 1'b0;
    checks++; if (ovr !== 1'b1 || drop !== 8'd1) begin errors++; $display("FAIL ovr_drop_wins: got %b/%0d required 1/1", ovr, drop); end
    ready = 1'b1;
    while (exp_q.size() > 0 && k < 20) begin
      if (valid === 1'b1) begin
        e = exp_q.pop_front();
        checks++;
        if (data !== e) begin errors++; $display("FAIL ovr_drain: got %h required %h", data, e); end
      end
      tick();
      k++;
    end
    checks++; if (valid !== 1'b0 || exp_q.size() != 0) begin errors++; $display("FAIL ovr_empty: got valid %b left %0d required 0/0", valid, exp_q.size()); end
  endtask

  task automatic test_full_pop();
    logic [7:0] e;
    int k = 0;
    do_reset();
    port = 8'h20; enable = 1'b1;
    run_strobes(4);
    checks++; if (level !== 3'd4) begin errors++; $display("FAIL fp_fill: got %0d required 4", level); end
    wait_strobe_cycle();
    ready = 1'b1;
    e = exp_q.pop_front();
    checks++; if (data !== e) begin errors++; $display("FAIL fp_head: got %h required %h", data, e); end
    exp_q.push_back(port);
    tick();
    ready = 1'b0; enable = 1'b0;
    checks++; if (level !== 3'd4) begin errors++; $display("FAIL fp_level: got %0d required 4", level); end
    checks++; if (drop !== 8'd0 || ovr !== 1'b0) begin errors++; $display("FAIL fp_nodrop: got %b/%0d required 0/0", ovr, drop); end
    ready = 1'b1;
    while (exp_q.size() > 0 && k < 20) begin
      if (valid === 1'b1) begin
        e = exp_q.pop_front();
        checks++;
        if (data !== e) begin errors++; $display("FAIL fp_drain: got %h required %h", data, e); end
      end
      tick();
      k++;
    end
    checks++; if (valid !== 1'b0 || exp_q.size() != 0) begin errors++; $display("FAIL fp_empty: got valid %b left %0d required 0/0", valid, exp_q.size()); end
  endtask

  task automatic test_disable_hold();
    logic [7:0] e;
    int k = 0;
    do_reset();
    port = 8'h30; enable = 1'b1;
    run_strobes(3);
    enable = 1'b0;
    repeat (12) tick();
    checks++; if (level !== 3'd3) begin errors++; $display("FAIL hold_level: got %0d required 3", level); end
    checks++; if (ad_clk !== 1'b0) begin errors++; $display("FAIL hold_ad_clk: got %b required 0", ad_clk); end
    ready = 1'b1;
    while (exp_q.size() > 0 && k < 20) begin
      if (valid === 1'b1) begin
        e = exp_q.pop_front();
        checks++;
        if (data !== e) begin errors++; $display("FAIL hold_drain: got %h required %h", data, e); end
      end
      tick();
      k++;
    end
    checks++; if (valid !== 1'b0 || level !== 3'd0) begin errors++; $display("FAIL hold_empty: got valid %b level %0d required 0/0", valid, level); end
  endtask

  initial begin
    rst = 1'b1; enable = 1'b0; ready = 1'b0; clr = 1'b0; port = 8'h00;
    prev_ad_clk = 1'b0; strobe_seen = 1'b0;
    test_reset();
    test_clock();
    test_capture();
    test_overrun();
    test_full_pop();
    test_disable_hold();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
